// File: rtl/sda_axi_lite_reg_master.sv
// AXI4-Lite slave to regReq/regAck register bus bridge: one transaction at a time,
// write/read arbitration on conflict, bounded request with SLVERR on timeout.
module sda_axi_lite_reg_master #(
  parameter int AxiAddrWidth  = 12,
  parameter int RegAddrWidth  = 8,
  parameter int TimeoutCycles = 64
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AxiAddrWidth-1:0] s_axi_awaddr,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [AxiAddrWidth-1:0] s_axi_araddr,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  output logic [3:0]              regWStrb,
  input  logic [31:0]             regRData
);

  localparam int CntWidth = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, ACC, REQ, RESP} state_t;

  state_t                  state, nextState;
  logic [CntWidth-1:0]     cnt;
  logic                    lastGrantRead;
  logic                    isRead;
  logic                    grantRead;
  logic                    wrPend, rdPend;
  logic                    timeoutHit;
  logic [RegAddrWidth-1:0] capAddr;
  logic                    unusedAddrBits;

  assign unusedAddrBits = ^{s_axi_awaddr, s_axi_araddr};

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState  = state;
    wrPend     = s_axi_awvalid & s_axi_wvalid;
    rdPend     = s_axi_arvalid;
    // On conflict the side not granted last time wins
    grantRead  = rdPend & (~wrPend | ~lastGrantRead);
    timeoutHit = (cnt == CntWidth'(TimeoutCycles - 1));
    capAddr    = isRead ? s_axi_araddr[RegAddrWidth-1:0] : s_axi_awaddr[RegAddrWidth-1:0];
    unique case (state)
      IDLE:    if (wrPend | rdPend) nextState = ACC;
      ACC:     nextState = REQ;
      REQ:     if (regAck | timeoutHit) nextState = RESP;
      RESP:    if (isRead ? s_axi_rready : s_axi_bready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      regReq        <= 1'b0;
      regWriteEn    <= 1'b0;
      regAddr       <= '0;
      regWData      <= '0;
      regWStrb      <= '0;
      cnt           <= '0;
      isRead        <= 1'b0;
      lastGrantRead <= 1'b1;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (nextState == ACC) begin
            isRead        <= grantRead;
            s_axi_awready <= ~grantRead;
            s_axi_wready  <= ~grantRead;
            s_axi_arready <= grantRead;
          end
        end
        ACC: begin
          lastGrantRead <= isRead;
          regReq        <= 1'b1;
          regWriteEn    <= ~isRead;
          regAddr       <= {capAddr[RegAddrWidth-1:2], 2'b00};
          regWData      <= isRead ? '0 : s_axi_wdata;
          regWStrb      <= isRead ? '0 : s_axi_wstrb;
          cnt           <= '0;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // Ack takes priority over a coincident timeout
          if (regAck | timeoutHit) begin
            regReq       <= 1'b0;
            regWriteEn   <= 1'b0;
            regAddr      <= '0;
            regWData     <= '0;
            regWStrb     <= '0;
            s_axi_bvalid <= ~isRead;
            s_axi_rvalid <= isRead;
            s_axi_bresp  <= (!isRead && !regAck) ? 2'b10 : 2'b00;
            s_axi_rresp  <= (isRead && !regAck) ? 2'b10 : 2'b00;
            s_axi_rdata  <= (isRead && regAck) ? regRData : '0;
          end
        end
        RESP: begin
          if (nextState == IDLE) begin
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_bresp  <= '0;
            s_axi_rresp  <= '0;
            s_axi_rdata  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
